// File: rtl/control_sequencer.sv
// control_sequencer: hardwired step-counter control unit for the single-bus
// DataPath. Runs fetch (T0..T2) and then the execute steps of the decoded
// instruction class. Memory steps can be stretched by MEM_WAIT extra cycles.
module control_sequencer #(
  parameter int                   OPCODE_W = 5,
  parameter int                   MEM_WAIT = 0,
  parameter logic [OPCODE_W-1:0]  ADD_OP   = OPCODE_W'(5'b00011)
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                run,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                Cout,
  output logic                Rout,
  output logic                BAout,
  output logic                enableMAR,
  output logic                enableMDR,
  output logic                enableIR,
  output logic                enableY,
  output logic                enableZ,
  output logic                enablePC,
  output logic                IncPC,
  output logic                Read,
  output logic                enableRAM,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic [OPCODE_W-1:0] alu_op,
  output logic [3:0]          step,
  output logic                busy,
  output logic                halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_RTYPE, C_ITYPE, C_NOP, C_HALT
  } iclass_e;

  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(5'b00000);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(5'b00001);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(5'b00010);
  localparam logic [OPCODE_W-1:0] OP_R_LO = OPCODE_W'(5'b00011);
  localparam logic [OPCODE_W-1:0] OP_R_HI = OPCODE_W'(5'b01011);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'b01100);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(5'b01101);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(5'b01110);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(5'b11011);
  localparam logic [OPCODE_W-1:0] AND_OP  = OPCODE_W'(5'b00101);
  localparam logic [OPCODE_W-1:0] OR_OP   = OPCODE_W'(5'b00110);
  localparam logic [2:0]          MEM_W   = 3'(MEM_WAIT);

  // Unknown opcodes (including the explicit nop code) fall into C_NOP.
  function automatic iclass_e classify(input logic [OPCODE_W-1:0] opc);
    if (opc == OP_LD)                         return C_LD;
    else if (opc == OP_LDI)                   return C_LDI;
    else if (opc == OP_ST)                    return C_ST;
    else if (opc >= OP_R_LO && opc <= OP_R_HI) return C_RTYPE;
    else if (opc == OP_ADDI || opc == OP_ANDI || opc == OP_ORI) return C_ITYPE;
    else if (opc == OP_HALT)                  return C_HALT;
    else                                      return C_NOP;
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            wait_q, wait_d;
  logic [OPCODE_W-1:0]   opc_q, opc_d;
  logic [OPCODE_W-1:0]   opc_in;
  iclass_e               cls_now, cls_q;
  state_e                end_state;
  logic                  unused_ir_bits;

  assign opc_in         = IR[31 -: OPCODE_W];
  assign unused_ir_bits = ^IR[31-OPCODE_W:0];
  assign cls_now        = classify(opc_in);
  assign cls_q          = classify(opc_q);
  assign end_state      = run ? S_T0 : S_IDLE;

  // State, wait counter and latched opcode registers.
  // NOTE: sequential state uses non-blocking assignments and an async reset;
  // clear drops every strobe at once, even mid way through a stretched step.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      opc_q   <= opc_d;
    end
  end

  // Next-state logic: step sequencing, wait stretching and decode at end of T2.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    opc_d   = opc_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = MEM_W;
      end
      S_T1: begin
        if (wait_q != 3'd0) wait_d = wait_q - 3'd1;
        else                state_d = S_T2;
      end
      S_T2: begin
        opc_d = opc_in;
        case (cls_now)
          C_NOP:   state_d = end_state;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_T3;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if (cls_q == C_LD || cls_q == C_ST) begin
          state_d = S_T6;
          wait_d  = MEM_W;
        end else begin
          state_d = end_state;
        end
      end
      S_T6: begin
        if (cls_q == C_LD && wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else begin
          state_d = S_T7;
          wait_d  = MEM_W;
        end
      end
      S_T7: begin
        if (cls_q == C_ST && wait_q != 3'd0) wait_d = wait_q - 3'd1;
        else                                 state_d = end_state;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered step and latched instruction class.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0; Rout = 1'b0;
    BAout = 1'b0; enableMAR = 1'b0; enableMDR = 1'b0; enableIR = 1'b0;
    enableY = 1'b0; enableZ = 1'b0; enablePC = 1'b0; IncPC = 1'b0;
    Read = 1'b0; enableRAM = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; alu_op = '0;
    case (state_q)
      S_T0: begin PCout = 1'b1; enableMAR = 1'b1; IncPC = 1'b1; enablePC = 1'b1; end
      S_T1: begin Read = 1'b1; enableMDR = 1'b1; end
      S_T2: begin MDRout = 1'b1; enableIR = 1'b1; end
      S_T3: begin
        Grb = 1'b1; enableY = 1'b1;
        if (cls_q == C_LD || cls_q == C_LDI || cls_q == C_ST) BAout = 1'b1;
        else                                                  Rout  = 1'b1;
      end
      S_T4: begin
        enableZ = 1'b1;
        case (cls_q)
          C_RTYPE: begin Grc = 1'b1; Rout = 1'b1; alu_op = opc_q; end
          C_ITYPE: begin
            Cout = 1'b1;
            if (opc_q == OP_ANDI)     alu_op = AND_OP;
            else if (opc_q == OP_ORI) alu_op = OR_OP;
            else                      alu_op = ADD_OP;
          end
          default: begin Cout = 1'b1; alu_op = ADD_OP; end
        endcase
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls_q == C_LD || cls_q == C_ST) enableMAR = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      S_T6: begin
        if (cls_q == C_ST) begin Gra = 1'b1; Rout = 1'b1; enableMDR = 1'b1; end
        else               begin Read = 1'b1; enableMDR = 1'b1; end
      end
      S_T7: begin
        if (cls_q == C_ST) enableRAM = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

  assign step   = state_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: three instances (MEM_WAIT 0, 2, 3)
// share Clock/clear/run/IR; each directed step checks the instance of interest.
module tb_control_sequencer;

  // Strobe vector bit positions.
  localparam logic [18:0] M_PCOUT = 19'd1 << 0;
  localparam logic [18:0] M_ZLOW  = 19'd1 << 1;
  localparam logic [18:0] M_MDRO  = 19'd1 << 2;
  localparam logic [18:0] M_COUT  = 19'd1 << 3;
  localparam logic [18:0] M_ROUT  = 19'd1 << 4;
  localparam logic [18:0] M_BAOUT = 19'd1 << 5;
  localparam logic [18:0] M_EMAR  = 19'd1 << 6;
  localparam logic [18:0] M_EMDR  = 19'd1 << 7;
  localparam logic [18:0] M_EIR   = 19'd1 << 8;
  localparam logic [18:0] M_EY    = 19'd1 << 9;
  localparam logic [18:0] M_EZ    = 19'd1 << 10;
  localparam logic [18:0] M_EPC   = 19'd1 << 11;
  localparam logic [18:0] M_INCPC = 19'd1 << 12;
  localparam logic [18:0] M_READ  = 19'd1 << 13;
  localparam logic [18:0] M_ERAM  = 19'd1 << 14;
  localparam logic [18:0] M_GRA   = 19'd1 << 15;
  localparam logic [18:0] M_GRB   = 19'd1 << 16;
  localparam logic [18:0] M_GRC   = 19'd1 << 17;
  localparam logic [18:0] M_RIN   = 19'd1 << 18;

  localparam logic [31:0] IR_LDI  = 32'h0880_0005;
  localparam logic [31:0] IR_LD   = 32'h0040_0000;
  localparam logic [31:0] IR_ST   = 32'h1000_0000;
  localparam logic [31:0] IR_ADD  = 32'h1800_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        run   = 1'b0;
  logic [31:0] IR    = 32'h0;

  logic [18:0] sv0, sv2, sv3;
  logic [4:0]  alu0, alu2, alu3;
  logic [3:0]  step0, step2, step3;
  logic        busy0, busy2, busy3;
  logic        halt0, halt2, halt3;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  control_sequencer #(.OPCODE_W(5), .MEM_WAIT(0), .ADD_OP(5'b00011)) u_w0 (
    .Clock(Clock), .clear(clear), .run(run), .IR(IR),
    .PCout(sv0[0]), .Zlowout(sv0[1]), .MDRout(sv0[2]), .Cout(sv0[3]),
    .Rout(sv0[4]), .BAout(sv0[5]), .enableMAR(sv0[6]), .enableMDR(sv0[7]),
    .enableIR(sv0[8]), .enableY(sv0[9]), .enableZ(sv0[10]), .enablePC(sv0[11]),
    .IncPC(sv0[12]), .Read(sv0[13]), .enableRAM(sv0[14]), .Gra(sv0[15]),
    .Grb(sv0[16]), .Grc(sv0[17]), .Rin(sv0[18]),
    .alu_op(alu0), .step(step0), .busy(busy0), .halted(halt0)
  );

  control_sequencer #(.OPCODE_W(5), .MEM_WAIT(2), .ADD_OP(5'b00011)) u_w2 (
    .Clock(Clock), .clear(clear), .run(run), .IR(IR),
    .PCout(sv2[0]), .Zlowout(sv2[1]), .MDRout(sv2[2]), .Cout(sv2[3]),
    .Rout(sv2[4]), .BAout(sv2[5]), .enableMAR(sv2[6]), .enableMDR(sv2[7]),
    .enableIR(sv2[8]), .enableY(sv2[9]), .enableZ(sv2[10]), .enablePC(sv2[11]),
    .IncPC(sv2[12]), .Read(sv2[13]), .enableRAM(sv2[14]), .Gra(sv2[15]),
    .Grb(sv2[16]), .Grc(sv2[17]), .Rin(sv2[18]),
    .alu_op(alu2), .step(step2), .busy(busy2), .halted(halt2)
  );

  control_sequencer #(.OPCODE_W(5), .MEM_WAIT(3), .ADD_OP(5'b00011)) u_w3 (
    .Clock(Clock), .clear(clear), .run(run), .IR(IR),
    .PCout(sv3[0]), .Zlowout(sv3[1]), .MDRout(sv3[2]), .Cout(sv3[3]),
    .Rout(sv3[4]), .BAout(sv3[5]), .enableMAR(sv3[6]), .enableMDR(sv3[7]),
    .enableIR(sv3[8]), .enableY(sv3[9]), .enableZ(sv3[10]), .enablePC(sv3[11]),
    .IncPC(sv3[12]), .Read(sv3[13]), .enableRAM(sv3[14]), .Gra(sv3[15]),
    .Grb(sv3[16]), .Grc(sv3[17]), .Rin(sv3[18]),
    .alu_op(alu3), .step(step3), .busy(busy3), .halted(halt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b0;
    #2;
    clear = 1'b1;
  endtask

  int n, t1_reads, t6_reads;
  logic done;

  initial begin
    // Reset state.
    #1 clear = 1'b0;
    #2;
    check("reset_step", 32'(step0), 32'd0);
    check("reset_strobes", 32'(sv0), 32'd0);
    check("reset_alu_busy_halt", {alu0, busy0, halt0}, 32'd0);

    // ldi, MEM_WAIT=0.
    IR = IR_LDI; run = 1'b1;
    clear = 1'b1;
    tick(); check("ldi_t0_step", 32'(step0), 32'd1);
    check("ldi_t0_strobes", 32'(sv0), 32'(M_PCOUT | M_EMAR | M_INCPC | M_EPC));
    check("ldi_t0_busy", 32'(busy0), 32'd1);
    tick(); check("ldi_t1_step", 32'(step0), 32'd2);
    check("ldi_t1_strobes", 32'(sv0), 32'(M_READ | M_EMDR));
    tick(); check("ldi_t2_step", 32'(step0), 32'd3);
    check("ldi_t2_strobes", 32'(sv0), 32'(M_MDRO | M_EIR));
    tick(); check("ldi_t3_step", 32'(step0), 32'd4);
    check("ldi_t3_strobes", 32'(sv0), 32'(M_GRB | M_BAOUT | M_EY));
    tick(); check("ldi_t4_step", 32'(step0), 32'd5);
    check("ldi_t4_strobes", 32'(sv0), 32'(M_COUT | M_EZ));
    check("ldi_t4_alu", 32'(alu0), 32'd3);
    tick(); check("ldi_t5_step", 32'(step0), 32'd6);
    check("ldi_t5_strobes", 32'(sv0), 32'(M_ZLOW | M_GRA | M_RIN));
    check("ldi_t5_alu", 32'(alu0), 32'd0);
    tick(); check("ldi_back_to_t0", 32'(step0), 32'd1);

    // Second ldi: run dropped during T4 must not truncate it.
    tick(); tick(); tick();
    tick(); check("drop_t4_step", 32'(step0), 32'd5);
    run = 1'b0;
    tick(); check("drop_t5_step", 32'(step0), 32'd6);
    check("drop_t5_strobes", 32'(sv0), 32'(M_ZLOW | M_GRA | M_RIN));
    tick(); check("drop_idle_step", 32'(step0), 32'd0);
    check("drop_idle_busy", 32'(busy0), 32'd0);
    tick(); check("drop_stays_idle", 32'(step0), 32'd0);

    // ld, MEM_WAIT=2: 12 cycles, Read high 3 cycles in T1 and 3 in T6.
    pulse_clear();
    IR = IR_LD; run = 1'b1;
    tick(); check("ld_t0_step", 32'(step2), 32'd1);
    n = 1; t1_reads = 0; t6_reads = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (step2 == 4'd1) done = 1'b1;
      else begin
        n++;
        if (sv2[13] && sv2[7] && step2 == 4'd2) t1_reads++;
        if (sv2[13] && sv2[7] && step2 == 4'd7) t6_reads++;
      end
    end
    check("ld_completed", 32'(done), 32'd1);
    check("ld_total_cycles", 32'(n), 32'd12);
    check("ld_t1_read_cycles", 32'(t1_reads), 32'd3);
    check("ld_t6_read_cycles", 32'(t6_reads), 32'd3);

    // st then add, MEM_WAIT=0.
    pulse_clear();
    IR = IR_ST; run = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("st_t6_step", 32'(step0), 32'd7);
    check("st_t6_strobes", 32'(sv0), 32'(M_GRA | M_ROUT | M_EMDR));
    tick(); check("st_t7_step", 32'(step0), 32'd8);
    check("st_t7_strobes", 32'(sv0), 32'(M_ERAM));
    IR = IR_ADD;
    tick(); check("st_end_t0_step", 32'(step0), 32'd1);
    check("st_end_no_ram", 32'(sv0[14]), 32'd0);
    tick(); tick();
    tick(); check("add_t3_strobes", 32'(sv0), 32'(M_GRB | M_ROUT | M_EY));
    tick(); check("add_t4_step", 32'(step0), 32'd5);
    check("add_t4_strobes", 32'(sv0), 32'(M_GRC | M_ROUT | M_EZ));
    check("add_t4_alu", 32'(alu0), 32'd3);

    // nop: fetch to fetch in 3 cycles.
    pulse_clear();
    IR = IR_NOP; run = 1'b1;
    tick(); tick(); tick();
    check("nop_t2_step", 32'(step0), 32'd3);
    tick(); check("nop_next_t0", 32'(step0), 32'd1);

    // halt: sticky, run ignored, only clear leaves.
    pulse_clear();
    IR = IR_HALT; run = 1'b1;
    tick(); tick(); tick();
    check("halt_t2_step", 32'(step0), 32'd3);
    tick(); check("halt_step", 32'(step0), 32'd15);
    check("halt_flag", 32'(halt0), 32'd1);
    check("halt_busy", 32'(busy0), 32'd0);
    check("halt_strobes", 32'(sv0), 32'd0);
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      tick();
      check("halt_sticky", 32'(step0), 32'd15);
    end
    clear = 1'b0;
    #1;
    check("halt_clear_step", 32'(step0), 32'd0);
    check("halt_clear_flag", 32'(halt0), 32'd0);
    clear = 1'b1;

    // Async clear mid-T1 with MEM_WAIT=3.
    IR = IR_LDI; run = 1'b1;
    tick(); check("aclr_t0_step", 32'(step3), 32'd1);
    tick(); check("aclr_t1_step", 32'(step3), 32'd2);
    check("aclr_t1_strobes", 32'(sv3), 32'(M_READ | M_EMDR));
    tick(); check("aclr_t1_held", 32'(step3), 32'd2);
    #3 clear = 1'b0;
    #1;
    check("aclr_step", 32'(step3), 32'd0);
    check("aclr_strobes", 32'(sv3), 32'd0);
    check("aclr_alu_busy_halt", {alu3, busy3, halt3}, 32'd0);
    clear = 1'b1;
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
